// File: rtl/instructions.sv
// Shared opcode set presented to the ICU; encodings follow the MC14500 ordering.
package instructions;

  typedef enum logic [3:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;

endpackage

// File: rtl/program_sequencer_pkg.sv
// Local types for the program sequencer control FSM.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_RELEASE,
    S_HALT
  } seq_state_e;

endpackage

// File: rtl/program_sequencer_sync2.sv
// Two-flop synchroniser for the asynchronous ICU acknowledge.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches opcode/operand words, hands each opcode to the ICU
// over a four-phase req/ack handshake, and steps the PC with a small return stack.
module program_sequencer
  import instructions::*;
  import program_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned STACK_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [PC_W+3:0]   mem_data,
  output logic              req,
  input  logic              ack,
  output instruction_t      instruction,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flag_f,
  output logic              halted,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int unsigned SP_W  = $clog2(STACK_D + 1);
  localparam int unsigned IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   operand_q, operand_d;
  instruction_t      instr_q, instr_d;
  logic              jmp_q, jmp_d;
  logic              rtn_q, rtn_d;
  logic              flag_q, flag_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [PC_W-1:0]   stack_q [STACK_D];
  logic [PC_W-1:0]   stack_d [STACK_D];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              run_low_q, run_low_d;
  logic              ack_s;
  logic [PC_W-1:0]   pc_inc;
  logic [SP_W-1:0]   sp_dec;

  sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack),
    .q     (ack_s)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign sp_dec = sp_q - SP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      operand_q <= '0;
      instr_q   <= NOPO;
      jmp_q     <= 1'b0;
      rtn_q     <= 1'b0;
      flag_q    <= 1'b0;
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      run_low_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_D; i++) stack_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      operand_q <= operand_d;
      instr_q   <= instr_d;
      jmp_q     <= jmp_d;
      rtn_q     <= rtn_d;
      flag_q    <= flag_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      run_low_q <= run_low_d;
      stack_q   <= stack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    operand_d = operand_q;
    instr_d   = instr_q;
    jmp_d     = jmp_q;
    rtn_d     = rtn_q;
    flag_d    = flag_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    run_low_d = run_low_q;
    stack_d   = stack_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        instr_d   = instruction_t'(mem_data[PC_W+3:PC_W]);
        operand_d = mem_data[PC_W-1:0];
        // Hold off req while a stale ack (e.g. ICU not yet reset) is still visible.
        if (!ack_s) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (ack_s) begin
          jmp_d   = jmp;
          rtn_d   = rtn;
          flag_d  = flag_f;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          if (jmp_q) begin
            pc_d = operand_q;
            if (sp_q == SP_W'(STACK_D)) begin
              ovf_d = 1'b1;
            end else begin
              stack_d[sp_q[IDX_W-1:0]] = pc_inc;
              sp_d = sp_q + SP_W'(1);
            end
          end else if (rtn_q) begin
            if (sp_q == '0) begin
              pc_d  = '0;
              unf_d = 1'b1;
            end else begin
              pc_d = stack_q[sp_dec[IDX_W-1:0]];
              sp_d = sp_dec;
            end
          end else begin
            pc_d = pc_inc;
          end
          run_low_d = !run;
          state_d   = (flag_q || !run) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (!run) begin
          run_low_d = 1'b1;
        end else if (run_low_q) begin
          run_low_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr    = pc_q;
  assign req         = (state_q == S_ISSUE);
  assign instruction = instr_q;
  assign halted      = (state_q == S_IDLE) || (state_q == S_HALT);
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a ROM model and a four-phase ICU model.
module tb_program_sequencer;
  import instructions::*;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned STACK_D = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              ack = 1'b0;
  logic              jmp = 1'b0;
  logic              rtn = 1'b0;
  logic              flag_f = 1'b0;
  logic [PC_W-1:0]   mem_addr;
  logic [PC_W+3:0]   mem_data = '0;
  logic              req;
  logic              halted;
  logic              stack_ovf;
  logic              stack_unf;
  instruction_t      instruction;

  logic [PC_W+3:0]   rom [256];
  int unsigned       ack_dly = 2;
  logic              force_both = 1'b0;

  int                n_vec = 0;
  int                n_err = 0;
  logic [PC_W-1:0]   addr_log [$];
  instruction_t      op_log [$];
  logic              ovf_log [$];
  int                req_viol = 0;
  logic              req_prev = 1'b0;

  program_sequencer #(.PC_W(PC_W), .STACK_D(STACK_D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .req         (req),
    .ack         (ack),
    .instruction (instruction),
    .jmp         (jmp),
    .rtn         (rtn),
    .flag_f      (flag_f),
    .halted      (halted),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[mem_addr];

  // Handshake log: one entry per rising req.
  always @(negedge clk) begin
    if (!rst_n) begin
      addr_log.delete();
      op_log.delete();
      ovf_log.delete();
      req_prev = 1'b0;
    end else begin
      if (req && !req_prev) begin
        addr_log.push_back(mem_addr);
        op_log.push_back(instruction);
        ovf_log.push_back(stack_ovf);
        if (ack) req_viol++;
      end
      req_prev = req;
    end
  end

  always begin
    @(negedge clk);
    if (!rst_n) begin
      ack = 1'b0; jmp = 1'b0; rtn = 1'b0; flag_f = 1'b0;
    end else if (req && !ack) begin
      repeat (ack_dly) @(negedge clk);
      jmp    = (instruction == JMP);
      rtn    = (instruction == RTN) || (force_both && instruction == JMP);
      flag_f = (instruction == NOPF);
      ack    = 1'b1;
    end else if (!req && ack) begin
      repeat (2) @(negedge clk);
      ack = 1'b0; jmp = 1'b0; rtn = 1'b0; flag_f = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = {NOPO, 8'h00};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    force_both = 1'b0;
    ack_dly = 2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_running(input string tag);
    int unsigned i = 0;
    while (halted && i < 100) begin @(negedge clk); i++; end
    chk({tag, "_started"}, halted, 1'b0);
  endtask

  task automatic wait_halted(input string tag);
    int unsigned i = 0;
    while (!halted && i < 4000) begin @(negedge clk); i++; end
    chk({tag, "_halted"}, halted, 1'b1);
  endtask

  task automatic wait_req(input string tag, input int n);
    int unsigned i = 0;
    while (addr_log.size() < n && i < 2000) begin @(negedge clk); i++; end
    chk({tag, "_req_seen"}, addr_log.size(), n);
  endtask

  logic [PC_W-1:0] t3_exp [10] = '{8'h00, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h41, 8'h31, 8'h21, 8'h01};

  initial begin
    clear_rom();
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_halted", halted, 1'b1);
    chk("rst_req", req, 1'b0);
    chk("rst_pc", mem_addr, 8'h00);
    chk("rst_instr", instruction, NOPO);
    chk("rst_ovf", stack_ovf, 1'b0);
    chk("rst_unf", stack_unf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Straight-line LD, OR, STO, NOPF
    rom[0] = {LD, 8'h05}; rom[1] = {OR, 8'h06}; rom[2] = {STO, 8'h07}; rom[3] = {NOPF, 8'h00};
    run = 1'b1;
    wait_running("t1");
    wait_halted("t1");
    chk("t1_hs_count", addr_log.size(), 4);
    chk("t1_op0", op_log[0], LD);
    chk("t1_op1", op_log[1], OR);
    chk("t1_op2", op_log[2], STO);
    chk("t1_op3", op_log[3], NOPF);
    chk("t1_pc", mem_addr, 8'h04);
    repeat (5) @(negedge clk);
    chk("t1_stays_halted", halted, 1'b1);

    // JMP / RTN round trip, then prove stack empty with an RTN underflow
    do_reset();
    clear_rom();
    rom[8'h10] = {JMP, 8'h40}; rom[8'h40] = {RTN, 8'h00};
    rom[8'h11] = {NOPF, 8'h00}; rom[8'h12] = {RTN, 8'h00};
    run = 1'b1;
    wait_running("t2");
    wait_halted("t2");
    chk("t2_hs_count", addr_log.size(), 19);
    chk("t2_fetch_jmp", addr_log[16], 8'h10);
    chk("t2_fetch_target", addr_log[17], 8'h40);
    chk("t2_fetch_return", addr_log[18], 8'h11);
    chk("t2_pc", mem_addr, 8'h12);
    chk("t2_unf", stack_unf, 1'b0);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    wait_running("t2b");
    wait_req("t2b", 20);
    run = 1'b0;
    wait_halted("t2b");
    chk("t2_empty_pop_pc", mem_addr, 8'h00);
    chk("t2_empty_pop_unf", stack_unf, 1'b1);

    // Five nested JMPs overflow; unwind shows the first four returns
    do_reset();
    clear_rom();
    rom[8'h00] = {JMP, 8'h20}; rom[8'h20] = {JMP, 8'h30}; rom[8'h30] = {JMP, 8'h40};
    rom[8'h40] = {JMP, 8'h50}; rom[8'h50] = {JMP, 8'h60};
    rom[8'h60] = {RTN, 8'h00}; rom[8'h41] = {RTN, 8'h00}; rom[8'h31] = {RTN, 8'h00};
    rom[8'h21] = {RTN, 8'h00}; rom[8'h01] = {NOPF, 8'h00};
    run = 1'b1;
    wait_running("t3");
    wait_halted("t3");
    chk("t3_hs_count", addr_log.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t3_fetch%0d", i), addr_log[i], t3_exp[i]);
    chk("t3_ovf_before_5th", ovf_log[4], 1'b0);
    chk("t3_ovf_after_5th", ovf_log[5], 1'b1);
    chk("t3_pc", mem_addr, 8'h02);
    chk("t3_ovf", stack_ovf, 1'b1);
    chk("t3_unf", stack_unf, 1'b0);

    // RTN on empty stack; underflow flag is sticky until reset
    do_reset();
    clear_rom();
    rom[0] = {RTN, 8'h00};
    run = 1'b1;
    wait_running("t4");
    wait_req("t4", 1);
    run = 1'b0;
    wait_halted("t4");
    chk("t4_pc", mem_addr, 8'h00);
    chk("t4_unf", stack_unf, 1'b1);
    chk("t4_ovf", stack_ovf, 1'b0);
    rom[0] = {NOPF, 8'h00};
    repeat (2) @(negedge clk);
    run = 1'b1;
    wait_running("t4b");
    wait_halted("t4b");
    chk("t4_pc_after", mem_addr, 8'h01);
    chk("t4_unf_sticky", stack_unf, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_unf_cleared", stack_unf, 1'b0);
    chk("t4_rst_pc", mem_addr, 8'h00);
    rst_n = 1'b1;

    // PC wrap 0xFF -> 0x00
    do_reset();
    clear_rom();
    rom[8'h00] = {JMP, 8'hFF};
    run = 1'b1;
    wait_running("t5");
    wait_req("t5", 3);
    run = 1'b0;
    wait_halted("t5");
    chk("t5_fetch0", addr_log[0], 8'h00);
    chk("t5_fetch1", addr_log[1], 8'hFF);
    chk("t5_fetch_wrap", addr_log[2], 8'h00);
    chk("t5_hs_count", addr_log.size(), 3);
    chk("t5_pc", mem_addr, 8'hFF);

    // run drops mid-handshake with slow ack
    do_reset();
    clear_rom();
    ack_dly = 10;
    rom[0] = {LD, 8'h11}; rom[1] = {NOPF, 8'h00};
    run = 1'b1;
    wait_running("t6");
    wait_req("t6", 1);
    repeat (2) @(negedge clk);
    chk("t6_req_held", req, 1'b1);
    run = 1'b0;
    wait_halted("t6");
    chk("t6_hs_count", addr_log.size(), 1);
    chk("t6_pc", mem_addr, 8'h01);
    repeat (3) @(negedge clk);
    chk("t6_stays_halted", halted, 1'b1);
    run = 1'b1;
    wait_running("t6b");
    wait_halted("t6b");
    chk("t6_resume_addr", addr_log[1], 8'h01);
    chk("t6_resume_op", op_log[1], NOPF);
    chk("t6_pc_after", mem_addr, 8'h02);

    // jmp and rtn together: jmp wins
    do_reset();
    clear_rom();
    force_both = 1'b1;
    rom[8'h00] = {JMP, 8'h33}; rom[8'h33] = {NOPF, 8'h00};
    run = 1'b1;
    wait_running("t7");
    wait_halted("t7");
    chk("t7_target", addr_log[1], 8'h33);
    chk("t7_pc", mem_addr, 8'h34);
    chk("t7_unf", stack_unf, 1'b0);

    chk("req_while_ack", req_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
